// File: rtl/dadda_mult_pipe.sv
// Three-stage pipelined Dadda-tree multiplier, WIDTH x WIDTH -> 2*WIDTH,
// with per-beat signed/unsigned mode and a valid/ready stream handshake.
module dadda_mult_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_sgn,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p
);

    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned HMAX = WIDTH + 1;
    localparam int unsigned NSEQ = 8;

    typedef logic [HMAX-1:0] col_t;

    // Dadda target heights, smallest first; 28 covers operands up to 32 bits.
    function automatic int unsigned dadda_h(input int unsigned k);
        case (k)
            0:       dadda_h = 2;
            1:       dadda_h = 3;
            2:       dadda_h = 4;
            3:       dadda_h = 6;
            4:       dadda_h = 9;
            5:       dadda_h = 13;
            6:       dadda_h = 19;
            default: dadda_h = 28;
        endcase
    endfunction

    // Builds the (Baugh-Wooley when sgn) partial-product array and reduces it
    // to two rows; returns {row1, row0}. Column bits are kept as a list per
    // column with a fill count, so each stage is a plain per-column recount.
    function automatic logic [2*PW-1:0] dadda_reduce(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             sgn
    );
        col_t            cur  [PW];
        col_t            nxt  [PW];
        int unsigned     cnt  [PW];
        int unsigned     ncnt [PW];
        int unsigned     d;
        int unsigned     excess;
        int unsigned     nfa;
        int unsigned     nha;
        int unsigned     idx;
        logic            x;
        logic            y;
        logic            z;
        logic [PW-1:0]   row0;
        logic [PW-1:0]   row1;

        for (int unsigned c = 0; c < PW; c++) begin
            cur[c] = '0;
            cnt[c] = 0;
        end

        // Cross terms involving exactly one operand MSB are inverted in signed mode.
        for (int unsigned i = 0; i < WIDTH; i++) begin
            for (int unsigned j = 0; j < WIDTH; j++) begin
                x = a[j] & b[i];
                if (sgn && ((i == WIDTH - 1) != (j == WIDTH - 1))) begin
                    x = ~x;
                end
                cur[i+j][cnt[i+j]] = x;
                cnt[i+j]++;
            end
        end

        // Baugh-Wooley correction ones; zero in unsigned mode keeps heights uniform.
        cur[WIDTH][cnt[WIDTH]] = sgn;
        cnt[WIDTH]++;
        cur[PW-1][cnt[PW-1]] = sgn;
        cnt[PW-1]++;

        for (int unsigned s = NSEQ; s > 0; s--) begin
            d = dadda_h(s - 1);
            for (int unsigned c = 0; c < PW; c++) begin
                nxt[c]  = '0;
                ncnt[c] = 0;
            end
            for (int unsigned c = 0; c < PW; c++) begin
                // ncnt[c] already holds the carries pushed in from column c-1.
                excess = (cnt[c] + ncnt[c] > d) ? (cnt[c] + ncnt[c] - d) : 0;
                nfa    = excess / 2;
                nha    = excess % 2;
                idx    = 0;
                for (int unsigned k = 0; k < HMAX; k++) begin
                    if (k < nfa) begin
                        x = cur[c][idx];
                        y = cur[c][idx+1];
                        z = cur[c][idx+2];
                        nxt[c][ncnt[c]] = x ^ y ^ z;
                        ncnt[c]++;
                        if (c + 1 < PW) begin
                            nxt[c+1][ncnt[c+1]] = (x & y) | (x & z) | (y & z);
                            ncnt[c+1]++;
                        end
                        idx += 3;
                    end
                end
                if (nha != 0) begin
                    x = cur[c][idx];
                    y = cur[c][idx+1];
                    nxt[c][ncnt[c]] = x ^ y;
                    ncnt[c]++;
                    if (c + 1 < PW) begin
                        nxt[c+1][ncnt[c+1]] = x & y;
                        ncnt[c+1]++;
                    end
                    idx += 2;
                end
                for (int unsigned k = 0; k < HMAX; k++) begin
                    if (k >= idx && k < cnt[c]) begin
                        nxt[c][ncnt[c]] = cur[c][k];
                        ncnt[c]++;
                    end
                end
            end
            cur = nxt;
            cnt = ncnt;
        end

        for (int unsigned c = 0; c < PW; c++) begin
            row0[c] = (cnt[c] > 0) ? cur[c][0] : 1'b0;
            row1[c] = (cnt[c] > 1) ? cur[c][1] : 1'b0;
        end
        return {row1, row0};
    endfunction

    logic               en_c;
    logic [2*PW-1:0]    rows_c;

    logic               s1_vld_q,  s1_vld_d;
    logic [WIDTH-1:0]   s1_a_q,    s1_a_d;
    logic [WIDTH-1:0]   s1_b_q,    s1_b_d;
    logic               s1_sgn_q,  s1_sgn_d;
    logic               s2_vld_q,  s2_vld_d;
    logic [PW-1:0]      s2_row0_q, s2_row0_d;
    logic [PW-1:0]      s2_row1_q, s2_row1_d;
    logic               s3_vld_q,  s3_vld_d;
    logic [PW-1:0]      s3_p_q,    s3_p_d;

    // Whole pipe advances when the output slot is empty or being drained.
    always_comb begin
        en_c = out_ready | ~s3_vld_q;
    end

    assign in_ready  = en_c;
    assign out_valid = s3_vld_q;
    assign out_p     = s3_p_q;

    // S2 reduction tree on the S1 operands.
    always_comb begin
        rows_c = dadda_reduce(s1_a_q, s1_b_q, s1_sgn_q);
    end

    // Next-state for all stages: shift on enable, hold otherwise.
    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        s1_sgn_d  = s1_sgn_q;
        s2_vld_d  = s2_vld_q;
        s2_row0_d = s2_row0_q;
        s2_row1_d = s2_row1_q;
        s3_vld_d  = s3_vld_q;
        s3_p_d    = s3_p_q;
        if (en_c) begin
            s1_vld_d  = in_valid;
            s1_a_d    = in_a;
            s1_b_d    = in_b;
            s1_sgn_d  = in_sgn;
            s2_vld_d  = s1_vld_q;
            s2_row0_d = rows_c[PW-1:0];
            s2_row1_d = rows_c[2*PW-1:PW];
            s3_vld_d  = s2_vld_q;
            s3_p_d    = s2_row0_q + s2_row1_q;
        end
    end

    // Stage registers with synchronous clear of valids and data.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_sgn_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_row0_q <= '0;
            s2_row1_q <= '0;
            s3_vld_q  <= 1'b0;
            s3_p_q    <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s1_sgn_q  <= s1_sgn_d;
            s2_vld_q  <= s2_vld_d;
            s2_row0_q <= s2_row0_d;
            s2_row1_q <= s2_row1_d;
            s3_vld_q  <= s3_vld_d;
            s3_p_q    <= s3_p_d;
        end
    end

endmodule
